// File: rtl/param_up_down_counter.sv
// Register-programmed up/down cycle counter: each cycle runs preload -> limit -> other limit -> preload.
// Leg order, continuous mode, abort and status readback are selected through a small bus register file.
module param_up_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ncs,
  input  logic             nrd,
  input  logic             nwr,
  input  logic [2:0]       A,
  inout  wire  [WIDTH-1:0] Din,
  input  logic             start_in,
  output logic [WIDTH-1:0] cout,
  output logic             err,
  output logic             ec,
  output logic             dir,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LEG0, LEG1, LEG2} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] plr, ulr, llr, ccr, remaining;
  logic [1:0]       mode;
  logic             start_prev;

  logic [WIDTH-1:0] cout_next, remaining_next, rd_data;
  logic [WIDTH-1:0] target0, target1, active_target, remaining_dec;
  logic             dir_next, busy_next, ec_next;
  logic             leg_found, cycle_end;
  state_t           active_leg;

  logic bus_wr, cfg_wr, abort, start_ok, down_first, continuous;

  assign down_first = mode[0];
  assign continuous = mode[1];
  assign bus_wr     = !ncs && !nwr;
  assign cfg_wr     = bus_wr && !busy;
  assign abort      = bus_wr && (A == 3'b110) && busy;
  assign start_ok   = start_in && !start_prev && (state == IDLE) && !err;

  assign target0       = down_first ? llr : ulr;
  assign target1       = down_first ? ulr : llr;
  assign remaining_dec = remaining - WIDTH'(1);

  // Configuration registers are frozen for the whole run so err cannot change mid-count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      plr  <= WIDTH'(1);
      ulr  <= '1;
      llr  <= '0;
      ccr  <= '0;
      mode <= 2'b00;
    end else if (cfg_wr) begin
      case (A)
        3'd0:    plr  <= Din;
        3'd1:    ulr  <= Din;
        3'd2:    llr  <= Din;
        3'd3:    ccr  <= Din;
        3'd4:    mode <= Din[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (A)
      3'd0:    rd_data = plr;
      3'd1:    rd_data = ulr;
      3'd2:    rd_data = llr;
      3'd3:    rd_data = ccr;
      3'd4:    rd_data = {{(WIDTH-2){1'b0}}, mode};
      3'd5:    rd_data = remaining;
      3'd7:    rd_data = {{(WIDTH-3){1'b0}}, busy, dir, err};
      default: rd_data = '0;
    endcase
  end

  assign Din = (!ncs && !nrd && nwr) ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cout       <= '0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      ec         <= 1'b0;
      remaining  <= '0;
      err        <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_next;
      cout       <= cout_next;
      dir        <= dir_next;
      busy       <= busy_next;
      ec         <= ec_next;
      remaining  <= remaining_next;
      err        <= (plr < llr) || (plr > ulr);
      start_prev <= start_in;
    end
  end

  // Empty legs are skipped within the same clock so every busy clock is a real step.
  always_comb begin
    state_next     = state;
    cout_next      = cout;
    dir_next       = dir;
    busy_next      = busy;
    ec_next        = 1'b0;
    remaining_next = remaining;
    leg_found      = 1'b0;
    active_leg     = LEG2;
    active_target  = plr;
    cycle_end      = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) begin
          if ((ccr == '0) && !continuous) begin
            ec_next = 1'b1;
          end else begin
            cout_next      = plr;
            remaining_next = ccr;
            busy_next      = 1'b1;
            state_next     = LEG0;
          end
        end
      end
      default: begin
        if ((state == LEG0) && (cout != target0)) begin
          leg_found     = 1'b1;
          active_leg    = LEG0;
          active_target = target0;
        end else if ((state != LEG2) && (cout != target1)) begin
          leg_found     = 1'b1;
          active_leg    = LEG1;
          active_target = target1;
        end else if (cout != plr) begin
          leg_found     = 1'b1;
          active_leg    = LEG2;
          active_target = plr;
        end

        if (leg_found) begin
          state_next = active_leg;
          if (cout < active_target) begin
            cout_next = cout + WIDTH'(1);
            dir_next  = 1'b1;
          end else begin
            cout_next = cout - WIDTH'(1);
            dir_next  = 1'b0;
          end
        end

        cycle_end = !leg_found || ((active_leg == LEG2) && (cout_next == plr));

        if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          cout_next  = cout;
          dir_next   = dir;
        end else if (cycle_end) begin
          state_next = LEG0;
          if (!continuous) begin
            remaining_next = remaining_dec;
            if (remaining_dec == '0) begin
              ec_next    = 1'b1;
              busy_next  = 1'b0;
              state_next = IDLE;
            end
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter: an 8-bit and a 4-bit instance share the control bus
// and run in lock-step; count sequences are checked against hand-computed tables.
module tb_param_up_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ncs, nrd, nwr, start_in, drive_en;
  logic [2:0] addr;
  logic [7:0] drive_data;
  wire  [7:0] din8;
  wire  [3:0] din4;

  assign din8 = drive_en ? drive_data : 8'bz;
  assign din4 = drive_en ? drive_data[3:0] : 4'bz;

  logic [7:0] cout8;
  logic [3:0] cout4;
  logic       err8, ec8, dir8, busy8;
  logic       err4, ec4, dir4, busy4;

  param_up_down_counter #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .ncs(ncs), .nrd(nrd), .nwr(nwr), .A(addr), .Din(din8),
    .start_in(start_in), .cout(cout8), .err(err8), .ec(ec8), .dir(dir8), .busy(busy8)
  );

  param_up_down_counter #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .ncs(ncs), .nrd(nrd), .nwr(nwr), .A(addr), .Din(din4),
    .start_in(start_in), .cout(cout4), .err(err4), .ec(ec4), .dir(dir4), .busy(busy4)
  );

  typedef struct {
    logic       load;
    logic [1:0] mode;
    logic [7:0] cout;
    logic       dir;
    logic       ec;
    logic       busy;
  } vec_t;

  vec_t       vecs [16];
  logic [7:0] seq8 [8];
  int         tests = 0;
  int         fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    addr = a; drive_data = d; drive_en = 1'b1; ncs = 1'b0; nwr = 1'b0;
    tick();
    ncs = 1'b1; nwr = 1'b1; drive_en = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    addr = a; ncs = 1'b0; nrd = 1'b0;
    #1;
    d = din8;
    ncs = 1'b1; nrd = 1'b1;
    check(name, 32'(d), 32'(exp));
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int ec_count;
    logic [7:0] exp;

    seq8 = '{8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3};
    vecs[0]  = '{1'b1, 2'd0, 8'd4, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 2'd0, 8'd5, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 8'd4, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 8'd3, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 8'd2, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 8'd1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 8'd2, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, 8'd3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 8'd2, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 2'd1, 8'd1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 2'd1, 8'd2, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 2'd1, 8'd3, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 2'd1, 8'd4, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 2'd1, 8'd5, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 2'd1, 8'd4, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 2'd1, 8'd3, 1'b0, 1'b1, 1'b0};

    reset = 1'b0; ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; start_in = 1'b0;
    drive_en = 1'b0; drive_data = 8'h00; addr = 3'd0;
    tick(); tick();
    reset = 1'b1;

    check("reset cout", 32'(cout8), 0);
    check("reset err", 32'(err8), 0);
    check("reset ec", 32'(ec8), 0);
    check("reset dir", 32'(dir8), 0);
    check("reset busy", 32'(busy8), 0);
    check_read("reset plr", 3'd0, 8'h01);
    check_read("reset ulr", 3'd1, 8'hff);
    check_read("reset ccr", 3'd3, 8'h00);

    bus_write(3'd0, 8'd3);
    bus_write(3'd1, 8'd5);
    bus_write(3'd2, 8'd1);
    bus_write(3'd3, 8'd1);
    tick();
    check("cfg err", 32'(err8), 0);

    // Up-first then down-first single cycles from the vector table.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].load) begin
        bus_write(3'd4, {6'd0, vecs[i].mode});
        start_pulse();
        check($sformatf("v%0d load cout", i), 32'(cout8), 3);
        check($sformatf("v%0d load busy", i), 32'(busy8), 1);
      end
      tick();
      check($sformatf("v%0d cout", i), 32'(cout8), 32'(vecs[i].cout));
      check($sformatf("v%0d dir", i), 32'(dir8), 32'(vecs[i].dir));
      check($sformatf("v%0d ec", i), 32'(ec8), 32'(vecs[i].ec));
      check($sformatf("v%0d busy", i), 32'(busy8), 32'(vecs[i].busy));
    end
    tick();
    check("ec one clock", 32'(ec8), 0);
    check("hold cout", 32'(cout8), 3);

    // Configuration error blocks start.
    bus_write(3'd0, 8'd7);
    check("err lag", 32'(err8), 0);
    tick();
    check("err set", 32'(err8), 1);
    check_read("status err", 3'd7, 8'h01);
    start_pulse();
    tick();
    check("err start busy", 32'(busy8), 0);
    check("err start cout", 32'(cout8), 3);
    bus_write(3'd0, 8'd3);
    tick();
    check("err clear", 32'(err8), 0);

    // Two cycles back to back.
    bus_write(3'd4, 8'd0);
    bus_write(3'd3, 8'd2);
    start_pulse();
    check_read("rem start", 3'd5, 8'd2);
    ec_count = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("ccr2 step%0d", i), 32'(cout8), 32'(seq8[i % 8]));
      if (ec8) ec_count++;
      if (i == 7) begin
        check_read("rem mid", 3'd5, 8'd1);
        check("ccr2 busy mid", 32'(busy8), 1);
      end
    end
    check("ccr2 ec count", ec_count, 1);
    check("ccr2 busy end", 32'(busy8), 0);
    check_read("rem end", 3'd5, 8'd0);

    // Skipped first leg on the 4-bit instance, no wrap at 15.
    bus_write(3'd1, 8'd15);
    bus_write(3'd0, 8'd15);
    bus_write(3'd2, 8'd0);
    bus_write(3'd3, 8'd1);
    tick();
    start_pulse();
    check("w4 load cout", 32'(cout4), 15);
    check("w4 load busy", 32'(busy4), 1);
    ec_count = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = (i <= 15) ? 8'(15 - i) : 8'(i - 15);
      check($sformatf("w4 step%0d", i), 32'(cout4), 32'(exp));
      if (i == 1) check("w4 dir down", 32'(dir4), 0);
      if (i == 16) check("w4 dir up", 32'(dir4), 1);
      if (ec4) ec_count++;
    end
    check("w4 ec end", 32'(ec4), 1);
    check("w4 ec count", ec_count, 1);
    check("w4 busy end", 32'(busy4), 0);

    bus_write(3'd3, 8'd0);
    start_pulse();
    check("ccr0 ec", 32'(ec4), 1);
    check("ccr0 cout", 32'(cout4), 15);
    check("ccr0 busy", 32'(busy4), 0);
    tick();
    check("ccr0 ec drop", 32'(ec4), 0);

    // Continuous run, locked config write, then abort.
    bus_write(3'd0, 8'd3);
    bus_write(3'd1, 8'd5);
    bus_write(3'd2, 8'd1);
    bus_write(3'd4, 8'd2);
    start_pulse();
    check("cont busy", 32'(busy8), 1);
    ec_count = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) bus_write(3'd3, 8'd7);
      else tick();
      check($sformatf("cont step%0d", i), 32'(cout8), 32'(seq8[(i - 1) % 8]));
      if (ec8) ec_count++;
    end
    check("cont no ec", ec_count, 0);
    check_read("cont rem", 3'd5, 8'd0);
    bus_write(3'd6, 8'h00);
    check("abort busy", 32'(busy8), 0);
    check("abort cout", 32'(cout8), 5);
    check("abort dir", 32'(dir8), 1);
    check("abort ec", 32'(ec8), 0);
    tick();
    check("abort hold", 32'(cout8), 5);
    check("abort ec later", 32'(ec8), 0);
    check_read("ccr locked", 3'd3, 8'd0);

    // Reset in the middle of a continuous run.
    start_pulse();
    tick(); tick();
    check("pre reset cout", 32'(cout8), 5);
    reset = 1'b0;
    tick();
    check("mid reset cout", 32'(cout8), 0);
    check("mid reset busy", 32'(busy8), 0);
    check("mid reset dir", 32'(dir8), 0);
    check("mid reset ec", 32'(ec8), 0);
    check_read("mid reset plr", 3'd0, 8'h01);
    check_read("mid reset mode", 3'd4, 8'h00);
    reset = 1'b1;
    bus_write(3'd0, 8'd9);
    bus_write(3'd1, 8'd200);
    check_read("post reset plr", 3'd0, 8'd9);
    check_read("post reset ulr", 3'd1, 8'd200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_up_down_counter.md
Name: param_up_down_counter

Overview:
Register-programmed up/down cycle counter, parametrised in width. It is the next generation of the 8-bit PLR/ULR/LLR/CCR counter. Each count cycle runs from the preload value out to one limit, across to the other limit, and back to the preload value, repeating CCR times. New over the 8-bit block: selectable leg order, continuous mode, software abort, status readback, fully synchronous start detection, and registers that can be rewritten after every run.

Parameters:
WIDTH, 8, data/count width; also width of Din and of all registers.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset
ncs  input  1  chip select, active-low, gates bus accesses only
nrd  input  1  read strobe, active-low
nwr  input  1  write strobe, active-low, has priority over nrd
A  input  3  register address
Din  inout  WIDTH  data bus; driven only when ncs=0, nrd=0, nwr=1, else high-Z
start_in  input  1  start request, synchronous, rising edge acts
cout  output  WIDTH  current count
err  output  1  configuration error flag
ec  output  1  end-of-count pulse, one clock
dir  output  1  1 = last step up, 0 = last step down
busy  output  1  run in progress

Behaviour:
- Reset (reset=0 at clock edge) sets:
  - PLR=1, ULR=all-ones, LLR=0, CCR=0, MODE=0, remaining=0.
  - cout=0, err=0, ec=0, dir=0, busy=0, state IDLE, start_in edge-detect register=0.
  - Reset mid-run takes the same path; no ec is produced.
- Register map:
  - 000 PLR, 001 ULR, 010 LLR, 011 CCR: read/write.
  - 100 MODE: bit0 down_first, bit1 continuous; other bits read 0.
  - 101 remaining cycles: read-only.
  - 110 ABORT: write-only, data ignored.
  - 111 STATUS: read-only, {0..., busy, dir, err}.
- Bus writes:
  - A write takes effect at the clock edge with ncs=0, nwr=0.
  - Writes to PLR/ULR/LLR/CCR/MODE are ignored while busy=1 and accepted again after busy falls.
  - Read data is a combinational mux of A. Reads have no side effects.
- err: registered every clock as (PLR<LLR)||(PLR>ULR) from current register values.
- Start:
  - Accepted on the clock where start_in=1, the previous sample was 0, state=IDLE and err=0.
  - Otherwise the edge is dropped; starts while busy are ignored.
  - Counting is independent of ncs.
- On accept with CCR=0 and continuous=0: next edge ec=1, cout unchanged, stays IDLE.
- On accept otherwise: cout<=PLR, remaining<=CCR, busy<=1, state LEG0.
- Legs:
  - up-first (down_first=0): LEG0 up to ULR, LEG1 down to LLR, LEG2 up to PLR.
  - down-first: LEG0 down to LLR, LEG1 up to ULR, LEG2 down to PLR.
- Stepping:
  - Each busy clock moves cout by exactly 1 toward the active leg's target and updates dir.
  - When cout already equals the target, that leg is skipped in the same clock and the step is taken in the next non-empty leg.
  - There is never a dwell clock and never a wrap-around.
- Cycle end:
  - A cycle ends on the step that lands cout on PLR in LEG2.
  - Degenerate case PLR=LLR=ULR: each cycle consumes one clock with cout held and dir unchanged.
  - At cycle end, remaining decrements. If remaining becomes 0 and continuous=0: ec=1 for that clock, busy=0, state IDLE, cout holds PLR.
  - Otherwise the run continues into LEG0 of the next cycle with no repeated value.
- continuous=1: CCR and remaining are ignored (remaining holds); the run stops only by abort or reset.
- Abort write: next edge busy=0, IDLE, cout and dir hold, no ec.
- Simultaneous events:
  - Abort beats cycle end; no ec is produced.
  - err rising mid-run is impossible because config writes are locked while busy.
  - ec and a new start edge in the same clock: the start is dropped.

Test Plan:
- WIDTH=8, PLR=3, ULR=5, LLR=1, CCR=1, MODE=0, start pulse → cout 3,4,5,4,3,2,1,2,3 on consecutive clocks; dir 1,1,0,0,0,0,1,1; ec=1 and busy=0 on the final 3 (8th clock after load).
- Same registers, MODE=1 → cout 3,2,1,2,3,4,5,4,3; ec on the final 3.
- Same registers, CCR=2 → 16 steps with the sequence repeated and no duplicate 3 at the boundary; remaining reads 2,1,0; a single ec.
- PLR=7, ULR=5 → err=1 the clock after the write; start is ignored (busy=0, cout unchanged); STATUS reads 001.
- WIDTH=4, PLR=ULR=15, LLR=0, CCR=1 → LEG0 skipped; cout 15,14..0,1..15 in 30 clocks with no wrap; ec at the end. Then CCR=0 with a start → ec next clock with no count.
- Continuous mode mid-run: an ABORT write freezes cout with busy=0 and no ec. A separate run with reset=0 mid-count → all registers and outputs return to reset values next edge, with writes to PLR/ULR accepted after busy falls.
